// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and types for the pipelined MIPS datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int ZERO_REG      = 0;
    localparam int SP_REG        = 29;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    // Stack pointer starts just below the kernel boundary
    localparam word_t SP_START_DEFAULT = 32'h7FFF_EFFC;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/register_file_bypass_register.sv
`default_nettype none
// ============================================================================
//  Module      : Register
//  Description : N-bit storage cell with load enable and a per-instance
//                asynchronous reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module Register
    import mips_pkg::*;
#(
    parameter int           N     = DEFAULT_WIDTH,
    parameter logic [N-1:0] START = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] DataInput,
    output logic [N-1:0] DataOutput
);

    logic [N-1:0] data_q;

    // Hold the stored word; reset forces START immediately, enable loads input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= START;
        end else if (enable) begin
            data_q <= DataInput;
        end
    end

    assign DataOutput = data_q;

endmodule : Register
`default_nettype wire

// File: rtl/register_file_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_bypass
//  Description : Decode-stage register file, one write port, READ_PORTS
//                combinational read ports with write-to-read bypass.
//                Register 0 reads zero; SP_INDEX resets to SP_START.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_bypass
    import mips_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter int               DEPTH      = DEFAULT_DEPTH,
    parameter int               READ_PORTS = 2,
    parameter int               SP_INDEX   = SP_REG,
    parameter logic [WIDTH-1:0] SP_START   = WIDTH'(32'h7FFF_EFFC),
    localparam int              AW         = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         write_enable,
    input  logic [AW-1:0]                write_addr,
    input  logic [WIDTH-1:0]             write_data,
    input  logic [READ_PORTS*AW-1:0]     read_addr,
    output logic [READ_PORTS*WIDTH-1:0]  read_data
);

    // Full address space so any AW-bit read address indexes a defined slot;
    // slot 0 and slots at or above DEPTH are tied to zero.
    localparam int SLOTS = 1 << AW;

    logic [WIDTH-1:0] reg_q [SLOTS];

    assign reg_q[ZERO_REG] = '0;

    for (genvar i = DEPTH; i < SLOTS; i++) begin : g_pad
        assign reg_q[i] = '0;
    end

    // Storage cells 1..DEPTH-1; clear reloads each cell with its own reset value
    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        localparam logic [WIDTH-1:0] START_VAL = (i == SP_INDEX) ? SP_START : '0;

        logic             hit;
        logic [WIDTH-1:0] reg_d;

        assign hit   = write_enable && (write_addr == AW'(i));
        assign reg_d = clear ? START_VAL : write_data;

        Register #(
            .N     (WIDTH),
            .START (START_VAL)
        ) u_reg (
            .clk        (clk),
            .reset      (reset),
            .enable     (hit || clear),
            .DataInput  (reg_d),
            .DataOutput (reg_q[i])
        );
    end

    // Per-port read mux; a same-cycle write to the read address wins unless clearing
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [AW-1:0] addr;
        logic          addr_ok;
        logic          bypass;

        assign addr    = read_addr[p*AW +: AW];
        assign addr_ok = (addr != '0) && (32'(addr) < 32'(DEPTH));
        assign bypass  = write_enable && !clear && (write_addr == addr);

        assign read_data[p*WIDTH +: WIDTH] = !addr_ok ? '0         :
                                             bypass   ? write_data :
                                                        reg_q[addr];
    end

endmodule : register_file_bypass
`default_nettype wire

// File: tb/tb_register_file_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_bypass
//  Description : Self-checking bench. DUT A: 32 regs, 3 read ports.
//                DUT B: 24 regs, 2 read ports, SP at 17 (out-of-range addrs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_bypass;

    localparam logic [31:0] SPA = 32'h7FFF_EFFC;
    localparam logic [31:0] SPB = 32'h0BAD_F00D;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [14:0] ra;
    logic [95:0] rd_a;
    logic [63:0] rd_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: plain arrays of architectural register contents
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];

    register_file_bypass #(
        .WIDTH(32), .DEPTH(32), .READ_PORTS(3), .SP_INDEX(29), .SP_START(SPA)
    ) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .write_enable(we),
        .write_addr(wa), .write_data(wd), .read_addr(ra), .read_data(rd_a)
    );

    register_file_bypass #(
        .WIDTH(32), .DEPTH(24), .READ_PORTS(2), .SP_INDEX(17), .SP_START(SPB)
    ) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .write_enable(we),
        .write_addr(wa), .write_data(wd), .read_addr(ra[9:0]), .read_data(rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_a(input logic [4:0] addr);
        if (addr == 5'd0)                          return 32'd0;
        if (we && !clear && wa == addr)            return wd;
        return mem_a[addr];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] addr);
        if (addr == 5'd0 || addr >= 5'd24)         return 32'd0;
        if (we && !clear && wa == addr)            return wd;
        return mem_b[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
        mem_a[29] = SPA;
        mem_b[17] = SPB;
    endtask

    // One rising edge; the model applies what the DUT sampled at that edge
    task automatic tick();
        logic        c, w, r;
        logic [4:0]  a;
        logic [31:0] d;
        c = clear; w = we; a = wa; d = wd;
        @(posedge clk);
        r = reset;
        if (!r || c) begin
            model_reset();
        end else if (w && a != 5'd0) begin
            mem_a[a] = d;
            if (a < 5'd24) mem_b[a] = d;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
        model_reset();
        #2;
        for (int addr = 0; addr < 32; addr++) begin
            clear = 1'($urandom);
            wd    = $urandom;
            wa    = 5'($urandom);
            ra    = {5'($urandom), 5'($urandom), 5'(addr)};
            #1;
            n_tests++;
            if (rd_a[31:0] !== ((addr == 29) ? SPA : 32'd0)) begin
                n_fail++;
                $display("FAIL reset_value addr %0d: got %h expected %h", addr, rd_a[31:0],
                         (addr == 29) ? SPA : 32'd0);
            end
            for (int p = 0; p < 3; p++) begin
                n_tests++;
                if (rd_a[p*32 +: 32] !== exp_a(ra[p*5 +: 5])) begin
                    n_fail++;
                    $display("FAIL reset_a port%0d addr %0d: got %h expected %h", p,
                             ra[p*5 +: 5], rd_a[p*32 +: 32], exp_a(ra[p*5 +: 5]));
                end
            end
            for (int p = 0; p < 2; p++) begin
                n_tests++;
                if (rd_b[p*32 +: 32] !== exp_b(ra[p*5 +: 5])) begin
                    n_fail++;
                    $display("FAIL reset_b port%0d addr %0d: got %h expected %h", p,
                             ra[p*5 +: 5], rd_b[p*32 +: 32], exp_b(ra[p*5 +: 5]));
                end
            end
        end
        tick();
        clear = 1'b0; we = 1'b0;
        #1 reset = 1'b1;
        tick();
        we = 1'b1; wa = 5'd5; wd = 32'h1234_5678;
        tick();
        we = 1'b0; ra = {5'd5, 5'd5, 5'd5};
        #1;
        n_tests++;
        if (rd_a[31:0] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL first_write reg5: got %h expected %h", rd_a[31:0], 32'h1234_5678);
        end
        n_tests++;
        if (rd_b[63:32] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL first_write_b reg5: got %h expected %h", rd_b[63:32], 32'h1234_5678);
        end
    endtask

    task automatic test_zero_oor();
        we = 1'b1; wd = 32'hFFFF_FFFF; wa = 5'd0;
        tick();
        wa = 5'd30;
        tick();
        we = 1'b0;
        for (int addr = 0; addr < 32; addr += 2) begin
            ra = {5'd0, 5'(addr + 1), 5'(addr)};
            #1;
            for (int p = 0; p < 2; p++) begin
                n_tests++;
                if (rd_b[p*32 +: 32] !== exp_b(ra[p*5 +: 5])) begin
                    n_fail++;
                    $display("FAIL zero_oor_b port%0d addr %0d: got %h expected %h", p,
                             ra[p*5 +: 5], rd_b[p*32 +: 32], exp_b(ra[p*5 +: 5]));
                end
            end
        end
        ra = {5'd0, 5'd0, 5'd30};
        #1;
        n_tests++;
        if (rd_b !== 64'd0) begin
            n_fail++;
            $display("FAIL oor_read_b: got %h expected %h", rd_b, 64'd0);
        end
        n_tests++;
        if (rd_a[31:0] !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reg30_a: got %h expected %h", rd_a[31:0], 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] old8;
        we = 1'b1; wa = 5'd8; wd = $urandom;
        old8 = wd;
        tick();
        we = 1'b1; wa = 5'd7; wd = 32'hCAFE_0001;
        ra = {5'd7, 5'd8, 5'd7};
        #1;
        n_tests++;
        if (rd_a[31:0] !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL bypass port0: got %h expected %h", rd_a[31:0], 32'hCAFE_0001);
        end
        n_tests++;
        if (rd_a[63:32] !== old8) begin
            n_fail++;
            $display("FAIL bypass port1_old: got %h expected %h", rd_a[63:32], old8);
        end
        n_tests++;
        if (rd_b[31:0] !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL bypass_b port0: got %h expected %h", rd_b[31:0], 32'hCAFE_0001);
        end
        tick();
        we = 1'b0;
        #1;
        n_tests++;
        if (rd_a[95:64] !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL stored reg7: got %h expected %h", rd_a[95:64], 32'hCAFE_0001);
        end
    endtask

    task automatic test_clear();
        we = 1'b1;
        for (int i = 1; i < 32; i++) begin
            wa = 5'(i); wd = 32'(i);
            tick();
        end
        clear = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h0000_DEAD;
        ra = {5'd5, 5'd29, 5'd3};
        #1;
        n_tests++;
        if (rd_a[31:0] !== 32'd3) begin
            n_fail++;
            $display("FAIL clear_no_bypass reg3: got %h expected %h", rd_a[31:0], 32'd3);
        end
        n_tests++;
        if (rd_a[63:32] !== 32'd29) begin
            n_fail++;
            $display("FAIL clear_cycle reg29: got %h expected %h", rd_a[63:32], 32'd29);
        end
        tick();
        clear = 1'b0; we = 1'b0;
        #1;
        n_tests++;
        if (rd_a !== {32'd0, SPA, 32'd0}) begin
            n_fail++;
            $display("FAIL after_clear: got %h expected %h", rd_a, {32'd0, SPA, 32'd0});
        end
        for (int addr = 0; addr < 32; addr += 2) begin
            ra = {5'd0, 5'(addr + 1), 5'(addr)};
            #1;
            for (int p = 0; p < 2; p++) begin
                n_tests++;
                if (rd_b[p*32 +: 32] !== exp_b(ra[p*5 +: 5])) begin
                    n_fail++;
                    $display("FAIL after_clear_b port%0d addr %0d: got %h expected %h", p,
                             ra[p*5 +: 5], rd_b[p*32 +: 32], exp_b(ra[p*5 +: 5]));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        we = 1'b1; wa = 5'd12; wd = 32'hAAAA_5555;
        tick();
        we = 1'b0; ra = {5'd12, 5'd12, 5'd12};
        #1;
        n_tests++;
        if (rd_a[31:0] !== 32'hAAAA_5555) begin
            n_fail++;
            $display("FAIL pre_reset reg12: got %h expected %h", rd_a[31:0], 32'hAAAA_5555);
        end
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (rd_a !== 96'd0) begin
            n_fail++;
            $display("FAIL async_reset reg12: got %h expected %h", rd_a, 96'd0);
        end
        we = 1'b1; wd = 32'h5555_AAAA;
        #1;
        n_tests++;
        if (rd_a[63:32] !== exp_a(5'd12)) begin
            n_fail++;
            $display("FAIL reset_bypass reg12: got %h expected %h", rd_a[63:32], exp_a(5'd12));
        end
        tick();
        we = 1'b0;
        #1;
        n_tests++;
        if (rd_a[31:0] !== 32'd0) begin
            n_fail++;
            $display("FAIL no_capture_in_reset reg12: got %h expected %h", rd_a[31:0], 32'd0);
        end
        reset = 1'b1; we = 1'b1; wd = 32'h0000_1111;
        tick();
        we = 1'b0;
        #1;
        n_tests++;
        if (rd_a[95:64] !== 32'h0000_1111) begin
            n_fail++;
            $display("FAIL first_write_after_reset reg12: got %h expected %h", rd_a[95:64],
                     32'h0000_1111);
        end
    endtask

    task automatic test_multiport();
        we = 1'b1; wa = 5'd29; wd = 32'h0000_1000;
        ra = {5'd29, 5'd29, 5'd29};
        #1;
        for (int p = 0; p < 3; p++) begin
            n_tests++;
            if (rd_a[p*32 +: 32] !== 32'h0000_1000) begin
                n_fail++;
                $display("FAIL multiport port%0d: got %h expected %h", p, rd_a[p*32 +: 32],
                         32'h0000_1000);
            end
        end
        tick();
        we = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we    = 1'($urandom);
            clear = ($urandom_range(0, 19) == 0);
            wa    = 5'($urandom);
            wd    = $urandom;
            for (int p = 0; p < 3; p++)
                ra[p*5 +: 5] = $urandom_range(0, 1) ? wa : 5'($urandom);
            #1;
            for (int p = 0; p < 3; p++) begin
                n_tests++;
                if (rd_a[p*32 +: 32] !== exp_a(ra[p*5 +: 5])) begin
                    n_fail++;
                    $display("FAIL random_a cyc %0d port%0d addr %0d: got %h expected %h", n, p,
                             ra[p*5 +: 5], rd_a[p*32 +: 32], exp_a(ra[p*5 +: 5]));
                end
            end
            for (int p = 0; p < 2; p++) begin
                n_tests++;
                if (rd_b[p*32 +: 32] !== exp_b(ra[p*5 +: 5])) begin
                    n_fail++;
                    $display("FAIL random_b cyc %0d port%0d addr %0d: got %h expected %h", n, p,
                             ra[p*5 +: 5], rd_b[p*32 +: 32], exp_b(ra[p*5 +: 5]));
                end
            end
            tick();
        end
        clear = 1'b0; we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_oor();
        test_bypass();
        test_clear();
        test_async_reset();
        test_multiport();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_register_file_bypass
`default_nettype wire
